// File: rtl/adc_row_capture.sv
// Captures a 2 x COLS ADC frame, then streams it row-major; first beat 1 cycle after capture end.
// Beats hold under out_ready=0 and the buffer is frozen while draining. Optional: BLACK_LEVEL_EN.
module adc_row_capture #(
  parameter int ADC_W       = 8,
  parameter int COLS        = 5,
  parameter int COL_W       = 3,
  parameter int BLACK_LEVEL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adc,
  input  logic             nre1,
  input  logic             nre2,
  input  logic             erase,
  input  logic [ADC_W-1:0] adc_data,
  output logic [ADC_W-1:0] out_data,
  output logic             out_row,
  output logic [COL_W-1:0] out_col,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_done,
  output logic             busy,
  output logic             overrun,
  output logic             row_err
);

`ifdef BLACK_LEVEL_EN
  localparam bit BL_ON = 1'b1;
`else
  localparam bit BL_ON = 1'b0;
`endif
  localparam logic [ADC_W-1:0] BL_C     = ADC_W'(BLACK_LEVEL);
  localparam logic [COL_W:0]   COLS_C   = (COL_W+1)'(COLS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [ADC_W-1:0] sample_q [2][COLS];
  logic [COL_W:0]   col_cnt [2];
  logic             last_row;
  logic             adc_d;
  logic             rd_row;
  logic [COL_W-1:0] rd_col;
  logic             frame_done_q, overrun_q, row_err_q;

  logic             row1_sel, row2_sel, smp_vld, smp_row, sel_err;
  logic             frame_end, beat_acc, last_beat, row_full;
  logic [COL_W:0]   cnt_sel;
  logic [ADC_W-1:0] wr_data;

  assign row1_sel  = ~nre1 & nre2;
  assign row2_sel  = nre1 & ~nre2;
  assign smp_vld   = adc & (row1_sel | row2_sel);
  assign smp_row   = row2_sel;
  assign sel_err   = adc & (nre1 == nre2);
  // nre2 has already released when adc falls, so the row comes from the registered last_row
  assign frame_end = adc_d & ~adc & last_row;
  assign beat_acc  = out_valid & out_ready;
  assign last_beat = rd_row & (rd_col == LAST_COL);
  assign cnt_sel   = col_cnt[smp_row];
  assign row_full  = (cnt_sel == COLS_C);

  always_comb begin
    wr_data = adc_data;
    if (BL_ON)
      wr_data = (adc_data > BL_C) ? adc_data - BL_C : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (smp_vld) state_nxt = CAPTURE;
      CAPTURE: if (frame_end) state_nxt = DRAIN;
      DRAIN:   if (beat_acc && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 2; r++) begin
        col_cnt[r] <= '0;
        for (int c = 0; c < COLS; c++) sample_q[r][c] <= '0;
      end
      last_row     <= 1'b0;
      adc_d        <= 1'b0;
      rd_row       <= 1'b0;
      rd_col       <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      row_err_q    <= 1'b0;
    end else begin
      adc_d        <= adc;
      frame_done_q <= 1'b0;
      if (sel_err) row_err_q <= 1'b1;
      case (state)
        IDLE: begin
          if (smp_vld) begin
            for (int r = 0; r < 2; r++) begin
              col_cnt[r] <= '0;
              for (int c = 0; c < COLS; c++) sample_q[r][c] <= '0;
            end
            sample_q[smp_row][0] <= wr_data;
            col_cnt[smp_row]     <= (COL_W+1)'(1);
            last_row             <= smp_row;
          end else if (erase) begin
            col_cnt[0] <= '0;
            col_cnt[1] <= '0;
          end
        end
        CAPTURE: begin
          if (smp_vld) begin
            last_row <= smp_row;
            if (row_full) begin
              overrun_q <= 1'b1;
            end else begin
              sample_q[smp_row][cnt_sel[COL_W-1:0]] <= wr_data;
              col_cnt[smp_row] <= cnt_sel + 1'b1;
            end
          end
          if (frame_end) begin
            rd_row <= 1'b0;
            rd_col <= '0;
          end
        end
        DRAIN: begin
          if (adc) overrun_q <= 1'b1;
          if (beat_acc) begin
            if (last_beat) begin
              frame_done_q <= 1'b1;
              rd_row       <= 1'b0;
              rd_col       <= '0;
            end else if (rd_col == LAST_COL) begin
              rd_row <= 1'b1;
              rd_col <= '0;
            end else begin
              rd_col <= rd_col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid  = (state == DRAIN);
  assign out_data   = sample_q[rd_row][rd_col];
  assign out_row    = rd_row;
  assign out_col    = rd_col;
  assign busy       = (state != IDLE);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign row_err    = row_err_q;

endmodule

// File: tb/tb_adc_row_capture.sv
// Table-driven frames with a beat scoreboard, plus drain-overrun and mid-drain reset sequences.
module tb_adc_row_capture;
  logic       clk = 1'b0;
  logic       reset, adc, nre1, nre2, erase, out_ready;
  logic [7:0] adc_data, out_data;
  logic       out_row, out_valid, frame_done, busy, overrun, row_err;
  logic [2:0] out_col;

  adc_row_capture #(.ADC_W(8), .COLS(5), .COL_W(3), .BLACK_LEVEL(12)) dut (
    .clk(clk), .reset(reset), .adc(adc), .nre1(nre1), .nre2(nre2), .erase(erase),
    .adc_data(adc_data), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done),
    .busy(busy), .overrun(overrun), .row_err(row_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       row;
    logic [2:0] col;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    int         n1;
    int         n2;
    logic [7:0] d1 [7];
    logic [7:0] d2 [5];
    bit         bad;
    bit         toggle;
    bit         exp_ovr;
    bit         exp_rerr;
  } vec_t;

  beat_t sb[$];
  int    checks = 0;
  int    failures = 0;
  int    done_cnt = 0;
  bit    held_vld = 0;
  beat_t held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] stored(input logic [7:0] d);
`ifdef BLACK_LEVEL_EN
    return (d > 8'd12) ? d - 8'd12 : 8'd0;
`else
    return d;
`endif
  endfunction

  function automatic vec_t mk(input int b1, input int n1, input int b2, input int n2,
                              input bit bad, input bit tog, input bit ovr, input bit rerr);
    vec_t v;
    v.n1 = n1; v.n2 = n2; v.bad = bad; v.toggle = tog; v.exp_ovr = ovr; v.exp_rerr = rerr;
    for (int i = 0; i < 7; i++) v.d1[i] = 8'(b1 + i);
    for (int i = 0; i < 5; i++) v.d2[i] = 8'(b2 + i);
    return v;
  endfunction

  // Beat checker: accepted beats pop the scoreboard; stalled beats must not change
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat actual=(%0d,%0d,%0d) required=none", out_row, out_col, out_data);
        end else begin
          check("beat", {out_row, out_col, out_data}, sb.pop_front());
        end
      end
      if (held_vld && out_valid) check("stall_hold", {out_row, out_col, out_data}, held);
      held_vld = out_valid && !out_ready;
      held     = {out_row, out_col, out_data};
      if (frame_done) begin
        done_cnt++;
        check("done_after_last_beat", sb.size(), 0);
      end
    end else begin
      held_vld = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    adc = 1'b0; nre1 = 1'b1; nre2 = 1'b1; adc_data = 8'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle_inputs(); erase = 1'b1; out_ready = 1'b1;
    tick(); tick();
    sb.delete();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {overrun, row_err, frame_done}, 0);
    check("rst_beat", {out_row, out_col, out_data}, 0);
    reset = 1'b0;
    tick();
  endtask

  task automatic push_expect(input vec_t v);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 5; c++) begin
        int n;
        logic [7:0] d;
        n = (r == 1) ? v.n2 : v.n1;
        d = (c < n) ? stored((r == 1) ? v.d2[c] : v.d1[c]) : 8'd0;
        sb.push_back({1'(r), 3'(c), d});
      end
  endtask

  task automatic drive_frame(input vec_t v);
    erase = 1'b0;
    if (v.bad) begin
      adc = 1'b1; nre1 = 1'b0; nre2 = 1'b0; adc_data = 8'd99; tick();
      idle_inputs(); tick();
    end
    for (int i = 0; i < v.n1; i++) begin
      adc = 1'b1; nre1 = 1'b0; nre2 = 1'b1; adc_data = v.d1[i]; tick();
    end
    idle_inputs(); tick();
    check("busy_after_row1", {busy, out_valid}, 2'b10);
    for (int i = 0; i < v.n2; i++) begin
      adc = 1'b1; nre1 = 1'b1; nre2 = 1'b0; adc_data = v.d2[i]; tick();
    end
    idle_inputs(); tick();
    check("first_valid_latency", out_valid, 1);
  endtask

  task automatic wait_done(input bit toggle, input int start);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      out_ready = toggle ? pat[k % 4] : 1'b1;
      tick();
      if (done_cnt != start) seen = 1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL frame_done_timeout actual=none required=pulse");
    end
    out_ready = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic finish_checks(input vec_t v, input int start);
    check("frame_done_count", done_cnt - start, 1);
    check("beats_left", sb.size(), 0);
    check("idle_after_frame", {busy, out_valid}, 0);
    check("overrun", overrun, v.exp_ovr);
    check("row_err", row_err, v.exp_rerr);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t v;
    int   start;
    reset = 1'b1; erase = 1'b1; out_ready = 1'b1; idle_inputs();

    vecs[0] = mk(10, 5, 20, 5, 0, 0, 0, 0);  // normal frame
    vecs[1] = mk(10, 5, 20, 5, 0, 1, 0, 0);  // backpressure 1,0,0,1
    vecs[2] = mk(1, 7, 30, 5, 0, 0, 1, 0);   // row 1 overrun
    vecs[3] = mk(40, 5, 50, 3, 1, 0, 0, 1);  // illegal select, short row 2
    vecs[4] = mk(0, 3, 20, 5, 0, 1, 0, 0);   // black level samples
    vecs[4].d1[0] = 8'd10; vecs[4].d1[1] = 8'd12; vecs[4].d1[2] = 8'd200;

    for (int i = 0; i < 5; i++) begin
      do_reset();
      start = done_cnt;
      push_expect(vecs[i]);
      drive_frame(vecs[i]);
      wait_done(vecs[i].toggle, start);
      finish_checks(vecs[i], start);
    end

    // adc strobes while draining: flagged, buffer untouched
    do_reset();
    start = done_cnt;
    push_expect(vecs[0]);
    out_ready = 1'b0;
    drive_frame(vecs[0]);
    adc = 1'b1; nre1 = 1'b0; adc_data = 8'hEE; tick(); tick();
    idle_inputs(); tick();
    check("drain_adc_overrun", overrun, 1);
    wait_done(0, start);
    v = vecs[0]; v.exp_ovr = 1;
    finish_checks(v, start);

    // reset after four accepted beats aborts the frame silently
    do_reset();
    v = vecs[0]; v.n1 = 6;
    push_expect(v);
    drive_frame(v);
    for (int k = 0; k < 4; k++) tick();
    check("beats_before_reset", sb.size(), 6);
    reset = 1'b1; out_ready = 1'b0;
    tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_frame_done", frame_done, 0);
    reset = 1'b0; out_ready = 1'b1; sb.delete();
    start = done_cnt;
    tick(); tick(); tick();
    check("midrst_no_done", done_cnt - start, 0);
    push_expect(vecs[0]);
    drive_frame(vecs[0]);
    wait_done(0, start);
    finish_checks(vecs[0], start);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_row_capture.md
Name: adc_row_capture

Overview:
- Downstream of the camera control FSM. Consumes its adc/nre1/nre2/erase strobes and the ADC sample bus.
- Captures one frame of 2 rows x COLS samples into an internal register buffer.
- Streams the frame out row-major over a valid/ready interface to the next stage, e.g. a frame store or serial link.
- Reports frame completion and protocol errors (overrun, illegal row select).

Parameters:
- ADC_W, 8, ADC sample width in bits.
- COLS, 5, samples per row; matches the 5 ADC read cycles per row of the control FSM.
- COL_W, 3, column index width; must satisfy 2**COL_W >= COLS.
- BLACK_LEVEL, 0, dark offset subtracted when BLACK_LEVEL_EN is defined.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- adc  in  1  ADC convert strobe from camera control; one sample per high cycle.
- nre1  in  1  row 1 select, active-low.
- nre2  in  1  row 2 select, active-low.
- erase  in  1  pixel erase from camera control; high while camera idle.
- adc_data  in  ADC_W  sample, valid in any cycle with adc=1.
- out_data  out  ADC_W  streamed sample.
- out_row  out  1  0=row 1, 1=row 2.
- out_col  out  COL_W  column index of out_data.
- out_valid  out  1  out_data/out_row/out_col valid.
- out_ready  in  1  downstream accepts when high with out_valid.
- frame_done  out  1  one-cycle pulse after last beat accepted.
- busy  out  1  high in CAPTURE or DRAIN.
- overrun  out  1  sticky error; cleared only by reset.
- row_err  out  1  sticky error; cleared only by reset.

Behaviour:
- Reset (synchronous, active-high) forces state IDLE. All outputs 0. Column counters, last_row and the sample buffer are cleared to 0. Reset mid-capture or mid-drain aborts the frame with no frame_done.
- States: IDLE, CAPTURE, DRAIN. Encoding is free.
- Sample qualifier: adc=1 with exactly one of nre1/nre2 low.
  - adc=1 with both low: sample dropped, row_err<=1.
  - adc=1 with both high: sample dropped, row_err<=1.
- IDLE:
  - erase=1: column counters cleared.
  - First qualified sample: buffer cleared, sample written at col 0 of its row, that row's counter<=1, state<=CAPTURE, busy<=1.
- CAPTURE:
  - Each qualified sample is written at buffer[row][col_cnt[row]], then col_cnt[row]++.
  - When col_cnt[row]==COLS: sample dropped, overrun<=1, counter holds (no wrap).
  - last_row is registered each qualified sample.
  - Frame end is detected on the registered adc falling edge (adc_d=1, adc=0) with last_row=row 2. State<=DRAIN. Note nre2 already deasserts in the same cycle adc falls, so the edge must use the registered last_row.
  - Falling edge after row 1 only: remain in CAPTURE.
- Short rows: unwritten columns stream out as 0.
- DRAIN:
  - out_valid=1 from the first DRAIN cycle.
  - Beat order: row 1 cols 0..COLS-1, then row 2 cols 0..COLS-1.
  - out_data/out_row/out_col are held stable while out_valid=1 and out_ready=0.
  - The beat advances only on out_valid & out_ready.
  - After the beat (row 2, col COLS-1) is accepted: out_valid<=0, frame_done<=1 for one cycle, state<=IDLE, busy<=0.
  - Any adc=1 cycle during DRAIN: sample dropped, overrun<=1, buffer untouched.
- Simultaneous events: qualified sample and falling-edge detect cannot coincide, since adc=0 on the edge. Reset has priority over everything.
- Throughput: 1 beat/cycle with out_ready held high. Capture-end to first out_valid is 1 cycle.

Optional Feature:
- BLACK_LEVEL_EN defined: each stored sample = adc_data - BLACK_LEVEL, saturating at 0 (unsigned, ADC_W bits). The subtraction is applied at capture; storage latency is unchanged.
- BLACK_LEVEL_EN undefined: samples stored unmodified and the BLACK_LEVEL parameter is ignored.

Test Plan:
- Normal frame:
  - Stimulus: row 1 = 5 cycles adc=1, nre1=0, data 10..14; 1 gap cycle; row 2 = 5 cycles, nre2=0, data 20..24; out_ready=1.
  - Response: 10 beats (0,0,10)..(1,4,24), then frame_done pulse and busy=0.
- Backpressure:
  - Stimulus: same frame, out_ready toggling 1,0,0,1.
  - Response: each beat held stable while stalled; order and values unchanged; exactly one frame_done.
- Overrun:
  - Stimulus 1: row 1 with 7 samples 1..7.
  - Response 1: beats row 1 = 1..5 and overrun=1.
  - Stimulus 2: separately, adc=1 during DRAIN.
  - Response 2: overrun=1, drained data unchanged.
- Row error / short row:
  - Stimulus: adc=1 with nre1=nre2=0, then row 2 with only 3 samples.
  - Response: row_err=1; row 2 beats cols 3,4 = 0.
- Reset mid-drain:
  - Stimulus: reset after beat 4.
  - Response: next cycle out_valid=0, busy=0, overrun=0, no frame_done. A following frame streams correctly from (0,0).
- BLACK_LEVEL_EN with BLACK_LEVEL=12:
  - Stimulus: data 10,12,200.
  - Response: stored 0,0,188.
